// File: rtl/result_demux_if.sv
// Handshake bundle for result_demux: one offered input word plus eight buffered output channels.
interface result_demux_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [2:0]           in_select;
  logic [7:0]           out_valid;
  logic [7:0]           out_ready;
  logic [8*WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_select, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_select, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/result_demux.sv
// 1:8 result demux: routes each accepted word to a one-entry buffer on the selected channel.
// Optional transfer counter (xfer_count) is built when RESULT_DEMUX_COUNT_EN is defined.
module result_demux #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  result_demux_if.slave      bus
`ifdef RESULT_DEMUX_COUNT_EN
  ,
  output logic [31:0]        xfer_count
`endif
);
  localparam int NCH = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e      state_q [NCH];
  chan_state_e      state_d [NCH];
  logic [WIDTH-1:0] buf_q   [NCH];
  logic [WIDTH-1:0] buf_d   [NCH];
  logic             in_ready_s;
  logic             accept_s;
  logic [NCH-1:0]   load_s;
  logic [NCH-1:0]   drain_s;

  // Ready depends only on the selected channel's state and its consumer, never on in_valid
  always_comb begin
    in_ready_s = 1'b0;
    if (state_q[bus.in_select] == EMPTY) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = bus.out_ready[bus.in_select];
    end
    accept_s = bus.in_valid & in_ready_s;
  end

  // Per-channel load and drain strobes
  always_comb begin
    load_s  = '0;
    drain_s = '0;
    for (int i = 0; i < NCH; i++) begin
      load_s[i]  = accept_s & (bus.in_select == 3'(i));
      drain_s[i] = (state_q[i] == FULL) & bus.out_ready[i];
    end
  end

  // Channel FSM next state: a load wins over a same-cycle drain so the channel refills without a bubble
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      buf_d[i]   = buf_q[i];
      case ({load_s[i], drain_s[i]})
        2'b10, 2'b11: begin
          state_d[i] = FULL;
          buf_d[i]   = bus.in_data;
        end
        2'b01: begin
          state_d[i] = EMPTY;
        end
        default: begin
          state_d[i] = state_q[i];
        end
      endcase
    end
  end

  // Channel state and buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= EMPTY;
        buf_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        buf_q[i]   <= buf_d[i];
      end
    end
  end

  assign bus.in_ready = in_ready_s;

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign bus.out_valid[g]               = (state_q[g] == FULL);
    assign bus.out_data[g*WIDTH +: WIDTH] = buf_q[g];
  end

`ifdef RESULT_DEMUX_COUNT_EN
  logic [31:0] xfer_count_q;
  logic [31:0] xfer_count_d;

  // Accept counter, wraps naturally at 32 bits
  always_comb begin
    if (accept_s) begin
      xfer_count_d = xfer_count_q + 32'd1;
    end else begin
      xfer_count_d = xfer_count_q;
    end
  end

  // Accept counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_count_q <= 32'd0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif
endmodule

// File: tb/tb_result_demux.sv
// Directed plus random bench for result_demux with a per-channel expected-word scoreboard.
module tb_result_demux;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  result_demux_if #(.WIDTH(W)) bus ();
`ifdef RESULT_DEMUX_COUNT_EN
  logic [31:0] xfer_count;
`endif

  result_demux #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RESULT_DEMUX_COUNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  logic [W-1:0] sb [8][$];
  int           drain_cnt [8];
  logic [31:0]  acc_cnt;
  int           n_pass  = 0;
  int           n_total = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [W-1:0] d, input logic [7:0] ordy);
    bus.in_valid  = v;
    bus.in_select = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // One clock: check ready, update scoreboard from the model, clock, check the channel outputs.
  task automatic cycle();
    logic         exp_rdy;
    logic [7:0]   ev;
    logic [255:0] em;
    logic [255:0] ed;
    #1;
    exp_rdy = (sb[bus.in_select].size() == 0) || bus.out_ready[bus.in_select];
    chk("in_ready", {255'd0, bus.in_ready}, {255'd0, exp_rdy});
    for (int i = 0; i < 8; i++) begin
      if (rst_n && sb[i].size() != 0 && bus.out_ready[i]) begin
        void'(sb[i].pop_front());
        drain_cnt[i]++;
      end
    end
    if (rst_n && bus.in_valid && exp_rdy) begin
      sb[bus.in_select].push_back(bus.in_data);
      acc_cnt = acc_cnt + 32'd1;
    end
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) sb[i].delete();
      acc_cnt = 32'd0;
    end
    @(posedge clk);
    #1;
    ev = 8'h00;
    em = '0;
    ed = '0;
    for (int i = 0; i < 8; i++) begin
      if (sb[i].size() != 0) begin
        ev[i] = 1'b1;
        em[i*W +: W] = '1;
        ed[i*W +: W] = sb[i][0];
      end
    end
    chk("out_valid", {248'd0, bus.out_valid}, {248'd0, ev});
    chk("out_data", bus.out_data & em, ed);
    if (!rst_n) chk("rst_data", bus.out_data, 256'd0);
`ifdef RESULT_DEMUX_COUNT_EN
    chk("xfer_count", {224'd0, xfer_count}, {224'd0, acc_cnt});
`endif
  endtask

  initial begin
    logic [255:0] exp_data;
    int           guard;
    acc_cnt = 32'd0;
    for (int i = 0; i < 8; i++) drain_cnt[i] = 0;

    // reset, with a word offered that must not be recorded
    rst_n = 1'b0;
    drive(1'b1, 3'd5, 32'h1111_1111, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("reset_valid", {248'd0, bus.out_valid}, 256'd0);
    rst_n = 1'b1;

    // routing
    drive(1'b1, 3'd5, 32'hDEAD_BEEF, 8'h00);
    cycle();
    exp_data = 256'd0;
    exp_data[5*W +: W] = 32'hDEAD_BEEF;
    chk("route_valid", {248'd0, bus.out_valid}, {248'd0, 8'h20});
    chk("route_data", bus.out_data, exp_data);

    // backpressure on channel 5 must not stall channel 2
    drive(1'b1, 3'd5, 32'h1234_5678, 8'h00);
    #1;
    chk("bp_ready5", {255'd0, bus.in_ready}, 256'd0);
    cycle();
    drive(1'b1, 3'd2, 32'h0000_CAFE, 8'h00);
    #1;
    chk("bp_ready2", {255'd0, bus.in_ready}, 256'd1);
    cycle();
    chk("bp_valid", {248'd0, bus.out_valid}, {248'd0, 8'h24});

    // in_valid low ignores data/select; out_ready on an empty channel does nothing
    drive(1'b0, 3'd0, 32'hFFFF_FFFF, 8'h01);
    cycle();
    chk("idle_valid", {248'd0, bus.out_valid}, {248'd0, 8'h24});
    chk("idle_ch5", {224'd0, bus.out_data[5*W +: W]}, {224'd0, 32'hDEAD_BEEF});

    // pass-through on channel 3
    drive(1'b1, 3'd3, 32'h0000_0001, 8'h00);
    cycle();
    drive(1'b1, 3'd3, 32'h0000_0002, 8'h08);
    cycle();
    chk("pt_valid3", {255'd0, bus.out_valid[3]}, 256'd1);
    chk("pt_data3", {224'd0, bus.out_data[3*W +: W]}, {224'd0, 32'h0000_0002});
    chk("pt_drains", 256'(drain_cnt[3]), 256'd1);

    // accept into 6 while draining 2
    drive(1'b1, 3'd6, 32'h0000_0066, 8'h04);
    cycle();
    chk("cross_valid", {248'd0, bus.out_valid}, {248'd0, 8'h68});

    // fill the rest, then drain all at once
    for (int c = 0; c < 8; c++) begin
      if (c != 3 && c != 5 && c != 6) begin
        drive(1'b1, 3'(c), 32'hA000_0000 | 32'(c), 8'h00);
        cycle();
      end
    end
    chk("all_full", {248'd0, bus.out_valid}, {248'd0, 8'hFF});
    drive(1'b0, 3'd0, 32'd0, 8'hFF);
    cycle();
    chk("multi_drain", {248'd0, bus.out_valid}, 256'd0);

    // random traffic
    for (int k = 0; k < 60; k++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 8'($urandom));
      cycle();
    end

    // reset mid-stream
    drive(1'b1, 3'd0, 32'h0000_00AA, 8'h00);
    cycle();
    drive(1'b1, 3'd7, 32'h0000_00BB, 8'h00);
    cycle();
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 8'h00);
    cycle();
    rst_n = 1'b1;
    chk("midrst_valid", {248'd0, bus.out_valid}, 256'd0);
    chk("midrst_data", bus.out_data, 256'd0);
`ifdef RESULT_DEMUX_COUNT_EN
    chk("midrst_count", {224'd0, xfer_count}, 256'd0);
`endif

    // ten accepts over random channels with random drains
    guard = 0;
    while (acc_cnt != 32'd10 && guard < 500) begin
      drive(1'b1, 3'($urandom_range(0, 7)), $urandom, 8'($urandom));
      cycle();
      guard++;
    end
    chk("ten_accepts", {224'd0, acc_cnt}, 256'd10);
`ifdef RESULT_DEMUX_COUNT_EN
    chk("count_10", {224'd0, xfer_count}, 256'd10);
    dut.xfer_count_q = 32'hFFFF_FFFF;
    acc_cnt = 32'hFFFF_FFFF;
    drive(1'b1, 3'd4, 32'h0000_0044, 8'hFF);
    cycle();
    chk("count_wrap", {224'd0, xfer_count}, 256'd0);
`endif

    // drain everything left
    drive(1'b0, 3'd0, 32'd0, 8'hFF);
    cycle();
    chk("final_empty", {248'd0, bus.out_valid}, 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
